sprite_ram_writer: RTL and testbench
====================================

SPRITE_RAM_WRITER -- requirements
Module: sprite_ram_writer

Interface
REQ-001 SHALL have parameter SPRITE_COLS, default 34, pixels per sprite row.
REQ-002 SHALL have parameter SPRITE_ROWS, default 34, pixel rows per sprite.
REQ-003 SHALL have parameter FRAME_COLS, default 3, sprite frames per sheet row.
REQ-004 SHALL have parameter FRAME_ROWS, default 8, sprite frame rows (orientations) per sheet.
REQ-005 SHALL use derived constants MEM_COLS = SPRITE_COLS*FRAME_COLS and FRAME_ROW_SIZE = MEM_COLS*SPRITE_ROWS (102 and 3468 at defaults).
REQ-006 SHALL have port clk, input, 1, single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, request to load one frame; sampled only in IDLE.
REQ-009 SHALL have port frame_row_sel, input, 3, target frame row.
REQ-010 SHALL have port frame_col_sel, input, 2, target frame column.
REQ-011 SHALL have port abort, input, 1, cancels a load in progress.
REQ-012 SHALL have port pix_data, input, 12, RGB444 pixel value.
REQ-013 SHALL have port pix_valid, input, 1, pix_data is valid.
REQ-014 SHALL have port pix_ready, output, 1, writer accepts a pixel this cycle.
REQ-015 SHALL have port wr_en, output, 1, sprite RAM write strobe.
REQ-016 SHALL have port wr_addr, output, 32, sprite RAM write address.
REQ-017 SHALL have port wr_data, output, 12, sprite RAM write data.
REQ-018 SHALL have port busy, output, 1, a load is in progress.
REQ-019 SHALL have port done, output, 1, one-cycle pulse when a frame load completes.
REQ-020 SHALL have port err, output, 1, one-cycle pulse when start is rejected.

Function
REQ-021 SHALL implement three states: IDLE, LOAD, and DONE.
REQ-022 In IDLE with start=1, SHALL latch frame_row_sel and frame_col_sel, clear x and y to 0, and enter LOAD on the next edge.
REQ-023 In IDLE with start=1 and (frame_row_sel >= FRAME_ROWS or frame_col_sel >= FRAME_COLS), SHALL stay in IDLE and pulse err for 1 cycle on the next cycle.
REQ-024 SHALL hold pix_ready=1 only in LOAD; a pixel is accepted when pix_valid and pix_ready are both 1.
REQ-025 For each accepted pixel, SHALL assert wr_en for exactly 1 cycle, on the cycle after acceptance.
REQ-026 With that wr_en, SHALL present wr_data = the accepted pix_data and wr_addr = row_sel*FRAME_ROW_SIZE + col_sel*SPRITE_COLS + y*MEM_COLS + x, using the x,y of the accepted pixel.
REQ-027 Pixel order is raster: x increments per accepted pixel; at x = SPRITE_COLS-1, x wraps to 0 and y increments.
REQ-028 When pix_valid=0 in LOAD, SHALL leave x and y unchanged and keep wr_en=0 in the following cycle (no bubbles written).
REQ-029 Acceptance of pixel (SPRITE_COLS-1, SPRITE_ROWS-1) SHALL move the state to DONE and deassert pix_ready from the next cycle.
REQ-030 In DONE, SHALL pulse done=1 in the same cycle as the final wr_en, then return to IDLE.
REQ-031 SHALL hold busy=1 in LOAD and DONE, and busy=0 in IDLE.
REQ-032 SHALL ignore start while in LOAD or DONE.
REQ-033 In LOAD with abort=1, SHALL return to IDLE on the next edge with no done pulse.
REQ-034 A pixel presented in the same cycle as abort SHALL NOT be accepted or written; writes from pixels accepted earlier SHALL still complete.
REQ-035 pix_data = 12'h000 (transparent) SHALL be written unchanged, with no special handling.
REQ-036 SHALL compute address arithmetic unsigned in 32 bits; the maximum address at defaults is 27743.

Reset
REQ-037 While reset=0, SHALL force IDLE and set pix_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, and x=y=0.
REQ-038 Reset asserted mid-LOAD SHALL drop any pending write; after reset releases, a new start SHALL begin at x=y=0.

Verification
REQ-039 Stimulus: start with sel (0,0), pix_valid held 1 for 1156 pixels. Required response: 1156 writes to addresses 0..33, 102..135, ..., 3366..3399; done asserted in the cycle of the 1156th wr_en; busy falls the cycle after.
REQ-040 Stimulus: load sel (1,0). Required response: first wr_addr=3468; the 35th pixel (x=0, y=1) is written at 3570.
REQ-041 Stimulus: load sel (7,2). Required response: first wr_addr=24344; last wr_addr=27743.
REQ-042 Stimulus: pix_valid toggled 1,0,1,0 during LOAD. Required response: wr_en follows one cycle later with the same pattern; addresses are consecutive with no skips.
REQ-043 Stimulus: start with sel (0,3). Required response: err pulses 1 cycle; busy stays 0; no writes.
REQ-044 Stimulus: abort after 10 pixels, with pixel 11 valid in the abort cycle; then reset=0 pulsed during a second load. Required response: exactly 10 writes and no done for the first load; all outputs return to 0 immediately on reset, with no further writes.

Source files
------------

// File: rtl/sprite_ram_writer_if.sv
// Pixel stream in and sprite RAM write port out of the sprite sheet loader.
interface sprite_ram_writer_if;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [11:0] wr_data;

  // Master feeds pixels and observes the RAM write port; slave is the writer.
  modport master (
    output pix_data, pix_valid,
    input  pix_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  pix_data, pix_valid,
    output pix_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/sprite_ram_writer.sv
// Loads one raster-ordered sprite frame from a pixel stream into the sprite
// sheet RAM at the frame position selected by row/column.
module sprite_ram_writer #(
  parameter int unsigned SPRITE_COLS = 34,
  parameter int unsigned SPRITE_ROWS = 34,
  parameter int unsigned FRAME_COLS  = 3,
  parameter int unsigned FRAME_ROWS  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          frame_row_sel,
  input  logic [1:0]          frame_col_sel,
  input  logic                abort,
  sprite_ram_writer_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned MEM_COLS       = SPRITE_COLS * FRAME_COLS;
  localparam int unsigned FRAME_ROW_SIZE = MEM_COLS * SPRITE_ROWS;
  localparam int unsigned XW             = (SPRITE_COLS > 1) ? $clog2(SPRITE_COLS) : 1;
  localparam int unsigned YW             = (SPRITE_ROWS > 1) ? $clog2(SPRITE_ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [31:0]   base_addr;
  logic [31:0]   row_addr;
  logic [31:0]   row_sel_ext;
  logic [31:0]   col_sel_ext;
  logic          sel_ok;
  logic          last_x;
  logic          last_y;

  assign row_sel_ext = 32'(frame_row_sel);
  assign col_sel_ext = 32'(frame_col_sel);
  assign sel_ok      = (row_sel_ext < FRAME_ROWS) && (col_sel_ext < FRAME_COLS);
  assign last_x      = (x == XW'(SPRITE_COLS - 1));
  assign last_y      = (y == YW'(SPRITE_ROWS - 1));

  // Frame origin is latched once at start; the row offset advances by
  // MEM_COLS per sprite row so no multiplier sits in the per-pixel path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      base_addr     <= '0;
      row_addr      <= '0;
      bus.pix_ready <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (sel_ok) begin
              state         <= LOAD;
              base_addr     <= row_sel_ext * FRAME_ROW_SIZE + col_sel_ext * SPRITE_COLS;
              row_addr      <= '0;
              x             <= '0;
              y             <= '0;
              busy          <= 1'b1;
              bus.pix_ready <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state         <= IDLE;
            busy          <= 1'b0;
            bus.pix_ready <= 1'b0;
          end else if (bus.pix_valid) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= base_addr + row_addr + 32'(x);
            bus.wr_data <= bus.pix_data;
            if (last_x) begin
              x <= '0;
              if (last_y) begin
                state         <= DONE;
                bus.pix_ready <= 1'b0;
                done          <= 1'b1;
              end else begin
                y        <= y + YW'(1);
                row_addr <= row_addr + MEM_COLS;
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Scoreboard bench for sprite_ram_writer: directed frame loads, flow control,
// rejected start, abort and mid-load reset.
module tb_sprite_ram_writer;

  localparam int unsigned SC = 34;
  localparam int unsigned SR = 34;
  localparam int unsigned MC = 102;
  localparam int unsigned FRS = 3468;
  localparam int unsigned NPIX = SC * SR;

  typedef struct packed {
    logic        last;
    logic [31:0] addr;
    logic [11:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] frame_row_sel;
  logic [1:0] frame_col_sel;
  logic       abort;
  logic       busy;
  logic       done;
  logic       err;

  sprite_ram_writer_if bus ();

  sprite_ram_writer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .frame_row_sel (frame_row_sel),
    .frame_col_sel (frame_col_sel),
    .abort         (abort),
    .bus           (bus.slave),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  int   compared = 0;
  int   mismatched = 0;
  int   writes = 0;
  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Monitor: every presented write must match the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (bus.wr_en === 1'b1) begin
      writes++;
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", bus.wr_addr, bus.wr_data);
      end else begin
        e = q.pop_front();
        check("wr_addr", bus.wr_addr, e.addr);
        check("wr_data", 32'(bus.wr_data), 32'(e.data));
        check("done_with_last_write", 32'(done), 32'(e.last));
      end
    end else if (done === 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL done_without_write: done=1 while wr_en=0 at %0t", $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int r, input int c);
    frame_row_sel = 3'(r);
    frame_col_sel = 2'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] pix_addr(input int r, input int c, input int i);
    return 32'(r * FRS + c * SC + (i / SC) * MC + (i % SC));
  endfunction

  // Streams pixels 0..n-1 back to back and queues their writes.
  task automatic feed(input int r, input int c, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = 12'(i * 37);
      e.last = (i == NPIX - 1);
      e.addr = pix_addr(r, c, i);
      e.data = 12'(i * 37);
      q.push_back(e);
      tick();
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic full_frame(input int r, input int c);
    do_start(r, c);
    check("busy_in_load", 32'(busy), 32'd1);
    check("pix_ready_in_load", 32'(bus.pix_ready), 32'd1);
    feed(r, c, NPIX);
    check("done_pulse", 32'(done), 32'd1);
    check("pix_ready_after_last", 32'(bus.pix_ready), 32'd0);
    check("busy_in_done", 32'(busy), 32'd1);
    tick();
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   n;
    int   w0;
    logic v;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    frame_row_sel = '0;
    frame_col_sel = '0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", bus.wr_addr, 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    reset = 1'b1;
    tick();

    // Full frames: origin, next frame row, and the far corner of the sheet.
    full_frame(0, 0);
    full_frame(1, 0);
    full_frame(7, 2);

    // Out-of-range column is rejected.
    do_start(0, 3);
    check("err_pulse", 32'(err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_pix_ready", 32'(bus.pix_ready), 32'd0);
    tick();
    check("err_one_cycle", 32'(err), 32'd0);
    check("err_still_idle", 32'(busy), 32'd0);

    // Alternating valid, then abort with an 11th pixel on the bus.
    w0 = writes;
    n = 0;
    do_start(3, 1);
    for (int k = 0; k < 20; k++) begin
      v = (k % 2 == 0);
      bus.pix_valid = v;
      bus.pix_data  = 12'(n + 12'h100);
      if (v) begin
        e.last = 1'b0;
        e.addr = pix_addr(3, 1, n);
        e.data = 12'(n + 12'h100);
        q.push_back(e);
        n++;
      end
      tick();
      check("wr_en_follows_valid", 32'(bus.wr_en), 32'(v));
    end
    bus.pix_valid = 1'b1;
    bus.pix_data  = 12'hABC;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.pix_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pix_ready", 32'(bus.pix_ready), 32'd0);
    check("abort_no_write", 32'(bus.wr_en), 32'd0);
    tick();
    tick();
    check("abort_write_count", 32'(writes - w0), 32'd10);

    // Reset during a load drops the write pending for the 5th pixel.
    do_start(4, 2);
    feed(4, 2, 4);
    bus.pix_valid = 1'b1;
    bus.pix_data  = 12'h555;
    tick();
    bus.pix_valid = 1'b0;
    w0 = writes;
    reset = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("mid_rst_wr_addr", bus.wr_addr, 32'd0);
    check("mid_rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("mid_rst_busy_ready", 32'({busy, bus.pix_ready}), 32'd0);
    check("mid_rst_done_err", 32'({done, err}), 32'd0);
    tick();
    tick();
    check("mid_rst_no_writes", 32'(writes - w0), 32'd0);
    reset = 1'b1;
    tick();

    // After reset a new load starts from x=y=0.
    do_start(5, 0);
    feed(5, 0, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    tick();
    check("queue_drained", 32'(q.size()), 32'd0);
    check("final_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
